fp_vec_add_issuer: RTL and testbench

FP_VEC_ADD_ISSUER -- requirements
Module: fp_vec_add_issuer

---
 rtl/fp_vec_add_issuer_if.sv | 41 ++++
 rtl/fp_vec_add_issuer.sv | 201 ++++++++++++++++++++
 tb/tb_fp_vec_add_issuer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_vec_add_issuer_if.sv
// fp_vec_add_issuer_if
//   Bundles the three handshake groups around the vector-add issuer:
//     upstream beats     s_valid / s_ready / s_vec
//     adder issue side   add_in_valid / add_op1 / add_op2
//     adder result side  add_out_valid / add_res
//     downstream results m_valid / m_ready / m_vec
//     status             err (sticky protocol error)
//   Vectors carry four W-bit lanes a..d, lane a in the MSBs.
//   modport master : the issuer's view (drives s_ready, add_*, m_valid, m_vec, err)
//   modport slave  : the surrounding system's view (upstream, adder, downstream)

interface fp_vec_add_issuer_if #(
  parameter int unsigned W = 12
);
  logic           s_valid;
  logic           s_ready;
  logic [4*W-1:0] s_vec;

  logic           add_in_valid;
  logic [4*W-1:0] add_op1;
  logic [4*W-1:0] add_op2;

  logic           add_out_valid;
  logic [4*W-1:0] add_res;

  logic           m_valid;
  logic           m_ready;
  logic [4*W-1:0] m_vec;

  logic           err;

  modport master (
    input  s_valid, s_vec, add_out_valid, add_res, m_ready,
    output s_ready, add_in_valid, add_op1, add_op2, m_valid, m_vec, err
  );

  modport slave (
    output s_valid, s_vec, add_out_valid, add_res, m_ready,
    input  s_ready, add_in_valid, add_op1, add_op2, m_valid, m_vec, err
  );
endinterface

// File: rtl/fp_vec_add_issuer.sv
// fp_vec_add_issuer
//   Pairs consecutive upstream vector beats into (op1, op2), issues each pair to an
//   external fixed-latency vector adder with a one-cycle strobe, and collects the
//   adder results in a small FIFO for the downstream consumer.
//
//   The adder cannot be stalled, so issue is gated by a credit rule: a pair may only
//   complete while (results in flight + results buffered) < RES_DEPTH. That keeps
//   every returning result guaranteed a FIFO slot.
//
//   Ports
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset; clears all state and forces s_ready low
//     bus  fp_vec_add_issuer_if.master (see interface header for the signal groups)
//
//   Lane contents are never inspected; everything passes through bit-exact.

module fp_vec_add_issuer #(
  parameter int unsigned EXP_BITS    = 5,
  parameter int unsigned MANT_BITS   = 6,
  parameter int unsigned RES_DEPTH   = 4,
  parameter int unsigned ADD_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_vec_add_issuer_if.master  bus
);

  localparam int unsigned W  = EXP_BITS + MANT_BITS + 1;
  localparam int unsigned VW = 4 * W;
  localparam int unsigned PW = $clog2(RES_DEPTH);
  localparam int unsigned CW = $clog2(RES_DEPTH + 1);

  // Elaboration-time parameter sanity.
  if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RES_DEPTH must be a power of two and at least 2");
  end
  if (ADD_LATENCY < 1) begin : g_bad_latency
    $error("ADD_LATENCY must be at least 1");
  end

  typedef enum logic [0:0] {
    StEmpty,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   op1_hold_q;
  logic [VW-1:0]   add_op1_q, add_op2_q;
  logic            issue_q;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   fifo_count_q, fifo_count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [VW-1:0]   mem_q [RES_DEPTH];
  logic            err_q, err_d;

  logic            credit_ok;
  logic            s_ready;
  logic            accept;
  logic            capture_op1;
  logic            issue;
  logic            push, pop, full, push_ok, push_drop, spurious;
  logic            inflight_dec;

  // ---------------------------------------------------------------------------
  // Upstream handshake and credit
  // ---------------------------------------------------------------------------
  // Sum in one extra bit so RES_DEPTH + RES_DEPTH cannot wrap.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count_q}) < (CW + 1)'(RES_DEPTH);

  // rst gates s_ready directly so it drops the moment reset is asserted.
  assign s_ready = !rst && ((state_q == StEmpty) || credit_ok);
  assign accept  = bus.s_valid && s_ready;

  // ---------------------------------------------------------------------------
  // Pairing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    capture_op1 = 1'b0;
    issue       = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          capture_op1 = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (accept) begin
          issue   = 1'b1;
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result FIFO control
  // ---------------------------------------------------------------------------
  assign push      = bus.add_out_valid;
  assign pop       = (fifo_count_q != '0) && bus.m_ready;
  assign full      = (fifo_count_q == CW'(RES_DEPTH));
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;
  // A result with nothing outstanding (e.g. a stale strobe after reset).
  assign spurious  = bus.add_out_valid && (inflight_q == '0);

  always_comb begin
    fifo_count_d = fifo_count_q;
    unique case ({push_ok, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // In-flight accounting: counted on the issue strobe, retired on the result
  // strobe. A stale result never drives the count below zero.
  // ---------------------------------------------------------------------------
  assign inflight_dec = bus.add_out_valid && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue_q, inflight_dec})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  assign err_d = err_q || spurious || push_drop;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEmpty;
      op1_hold_q   <= '0;
      add_op1_q    <= '0;
      add_op2_q    <= '0;
      issue_q      <= 1'b0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_q      <= issue;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      err_q        <= err_d;
      if (capture_op1) begin
        op1_hold_q <= bus.s_vec;
      end
      // Operand registers only move on issue, so they hold between strobes.
      if (issue) begin
        add_op1_q <= op1_hold_q;
        add_op2_q <= bus.s_vec;
      end
      // Pointers wrap naturally: RES_DEPTH is a power of two.
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.add_res;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.s_ready      = s_ready;
  assign bus.add_in_valid = issue_q;
  assign bus.add_op1      = add_op1_q;
  assign bus.add_op2      = add_op2_q;
  assign bus.m_valid      = (fifo_count_q != '0);
  assign bus.m_vec        = mem_q[rd_ptr_q];
  assign bus.err          = err_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    fifo_count_q <= CW'(RES_DEPTH));
  a_inflight_bound : assert property (@(posedge clk) disable iff (rst)
    inflight_q <= CW'(RES_DEPTH));

endmodule

// File: tb/tb_fp_vec_add_issuer.sv
module tb_fp_vec_add_issuer;

  localparam int unsigned EXP_BITS    = 5;
  localparam int unsigned MANT_BITS   = 6;
  localparam int unsigned RES_DEPTH   = 4;
  localparam int unsigned ADD_LATENCY = 3;
  localparam int unsigned W           = EXP_BITS + MANT_BITS + 1;
  localparam int unsigned VW          = 4 * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_vec_add_issuer_if #(.W(W)) ifc ();

  fp_vec_add_issuer #(
    .EXP_BITS   (EXP_BITS),
    .MANT_BITS  (MANT_BITS),
    .RES_DEPTH  (RES_DEPTH),
    .ADD_LATENCY(ADD_LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // ---------------------------------------------------------------------------
  // Reference lane adder: same-sign normals, align, add, one-step normalise,
  // truncate.
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] fp_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0]           a, b;
    logic [EXP_BITS-1:0]    ea, eb;
    logic [MANT_BITS:0]     ma, mb;
    logic [MANT_BITS+1:0]   s;
    if (y[W-2:MANT_BITS] > x[W-2:MANT_BITS]) begin
      a = y; b = x;
    end else begin
      a = x; b = y;
    end
    ea = a[W-2:MANT_BITS];
    eb = b[W-2:MANT_BITS];
    ma = {1'b1, a[MANT_BITS-1:0]};
    mb = {1'b1, b[MANT_BITS-1:0]};
    mb = mb >> (ea - eb);
    s  = {1'b0, ma} + {1'b0, mb};
    if (s[MANT_BITS+1]) fp_add = {a[W-1], ea + EXP_BITS'(1), s[MANT_BITS:1]};
    else                fp_add = {a[W-1], ea, s[MANT_BITS-1:0]};
  endfunction

  function automatic logic [VW-1:0] fp_add_vec(input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [VW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*W +: W] = fp_add(x[i*W +: W], y[i*W +: W]);
    return r;
  endfunction

  function automatic logic [VW-1:0] v4(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] c, input logic [W-1:0] d);
    return {a, b, c, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Adder model: result strobe rises ADD_LATENCY edges after the edge that
  // samples add_in_valid. Not reset, so results outlive a DUT reset.
  // ---------------------------------------------------------------------------
  logic [ADD_LATENCY:0] vsr = '0;
  logic [VW-1:0]        dsr [ADD_LATENCY+1];

  always @(posedge clk) begin
    vsr    <= {vsr[ADD_LATENCY-1:0], ifc.add_in_valid};
    dsr[0] <= fp_add_vec(ifc.add_op1, ifc.add_op2);
    for (int i = 1; i <= ADD_LATENCY; i++) dsr[i] <= dsr[i-1];
  end

  assign ifc.add_out_valid = vsr[ADD_LATENCY];
  assign ifc.add_res       = dsr[ADD_LATENCY];

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_issue = 0;
  int            n_pop = 0;
  bit            sb_on = 0;
  bit            rand_rdy = 0;
  bit            have_b1 = 0;
  logic [VW-1:0] b1;
  logic [VW-1:0] q[$];

  typedef struct {
    logic [VW-1:0] beat1;
    logic [VW-1:0] beat2;
    logic [VW-1:0] res;
  } vec_t;
  vec_t tbl[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: scoreboard the pop that the coming edge performs, then advance to
  // 1 ns past the edge.
  task automatic step();
    logic [VW-1:0] e;
    if (ifc.add_in_valid) n_issue++;
    if (sb_on && ifc.m_valid && ifc.m_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got %h, required no result (t=%0t)", ifc.m_vec, $time);
      end else begin
        e = q.pop_front();
        check("sb_result", ifc.m_vec, e);
        n_pop++;
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) ifc.m_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer a beat for up to bound cycles; returns 1 ns after the accepting edge.
  task automatic beat(input logic [VW-1:0] v, input int bound, output bit acc);
    ifc.s_valid = 1'b1;
    ifc.s_vec   = v;
    acc = 1'b0;
    for (int k = 0; k < bound && !acc; k++) begin
      if (ifc.s_ready) acc = 1'b1;
      step();
    end
    ifc.s_valid = 1'b0;
    if (acc) begin
      if (have_b1) begin
        q.push_back(fp_add_vec(b1, v));
        have_b1 = 1'b0;
      end else begin
        b1 = v;
        have_b1 = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [VW-1:0] v);
    bit acc;
    beat(v, 50, acc);
    check("accept", 64'(acc), 64'd1);
  endtask

  task automatic drain(input int bound);
    for (int k = 0; k < bound && q.size() != 0; k++) step();
    check("drain_empty", 64'(q.size()), 64'd0);
    step();
    step();
    check("drain_no_extra", 64'(ifc.m_valid), 64'd0);
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return VW'({$urandom(), $urandom()});
  endfunction

  initial begin
    bit            acc;
    int            nacc;
    logic [VW-1:0] bp [10];

    tbl[0] = '{v4(12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0),
               v4(12'h400, 12'h400, 12'h400, 12'h400),
               v4(12'h420, 12'h420, 12'h420, 12'h420)};
    tbl[1] = '{v4(12'h3C0, 12'h400, 12'h3E0, 12'h3C0),
               v4(12'h3C0, 12'h400, 12'h3C0, 12'h400),
               v4(12'h400, 12'h440, 12'h410, 12'h420)};
    tbl[2] = '{v4(12'h380, 12'h3C0, 12'h380, 12'h440),
               v4(12'h3C0, 12'h380, 12'h380, 12'h3C0),
               v4(12'h3E0, 12'h3E0, 12'h3C0, 12'h450)};

    ifc.s_valid = 1'b0;
    ifc.s_vec   = '0;
    ifc.m_ready = 1'b0;

    // ---- reset state (checked before any clock edge) ----
    #2 rst = 1'b1;
    #1;
    check("rst_s_ready", 64'(ifc.s_ready), 64'd0);
    check("rst_m_valid", 64'(ifc.m_valid), 64'd0);
    check("rst_add_in_valid", 64'(ifc.add_in_valid), 64'd0);
    check("rst_err", 64'(ifc.err), 64'd0);
    check("rst_op1", 64'(ifc.add_op1), 64'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", 64'(ifc.s_ready), 64'd1);

    // ---- table-driven basic pairs with exact latency ----
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].beat1);
      check("tbl_no_issue_on_op1", 64'(ifc.add_in_valid), 64'd0);
      send(tbl[i].beat2);
      check("tbl_issue", 64'(ifc.add_in_valid), 64'd1);
      check("tbl_op1", 64'(ifc.add_op1), 64'(tbl[i].beat1));
      check("tbl_op2", 64'(ifc.add_op2), 64'(tbl[i].beat2));
      step();
      check("tbl_issue_one_cycle", 64'(ifc.add_in_valid), 64'd0);
      check("tbl_op1_held", 64'(ifc.add_op1), 64'(tbl[i].beat1));
      step();
      step();
      step();
      check("tbl_lat_early", 64'(ifc.m_valid), 64'd0);
      step();
      check("tbl_lat_m_valid", 64'(ifc.m_valid), 64'd1);
      check("tbl_m_vec", 64'(ifc.m_vec), 64'(tbl[i].res));
      ifc.m_ready = 1'b1;
      step();
      ifc.m_ready = 1'b0;
      check("tbl_popped", 64'(ifc.m_valid), 64'd0);
    end
    q.delete();

    // ---- odd tail: single beat then idle ----
    n_issue = 0;
    send(v4(12'h3C0, 12'h380, 12'h400, 12'h440));
    for (int k = 0; k < 6; k++) step();
    check("tail_no_issue", 64'(n_issue), 64'd0);
    check("tail_s_ready", 64'(ifc.s_ready), 64'd1);
    sb_on = 1'b1;
    send(v4(12'h400, 12'h3C0, 12'h380, 12'h3C0));
    check("tail_hold_issue", 64'(ifc.add_in_valid), 64'd1);
    ifc.m_ready = 1'b1;
    drain(20);
    ifc.m_ready = 1'b0;

    // ---- simultaneous issue/result and push/pop ----
    send(rnd_vec());                // D1
    send(rnd_vec());                // D2, result lands 4 cycles on
    step();
    step();
    send(rnd_vec());                // C1
    send(rnd_vec());                // C2: issue cycle coincides with D's result
    check("sim_issue", 64'(ifc.add_in_valid), 64'd1);
    check("sim_result", 64'(ifc.add_out_valid), 64'd1);
    check("sim_inflight_before", 64'(dut.inflight_q), 64'd1);
    step();
    check("sim_inflight_after", 64'(dut.inflight_q), 64'd1);
    check("sim_count_one", 64'(dut.fifo_count_q), 64'd1);
    step();
    step();
    step();
    check("sim_c_result", 64'(ifc.add_out_valid), 64'd1);
    ifc.m_ready = 1'b1;             // pop D while C is pushed
    step();
    check("sim_count_unchanged", 64'(dut.fifo_count_q), 64'd1);
    drain(10);
    ifc.m_ready = 1'b0;
    check("sim_err", 64'(ifc.err), 64'd0);

    // ---- backpressure: 10 beats into a stalled sink ----
    n_issue = 0;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      bp[i] = rnd_vec();
      beat(bp[i], 20, acc);
      nacc += int'(acc);
    end
    check("bp_accepted", 64'(nacc), 64'd9);
    check("bp_issues", 64'(n_issue), 64'(RES_DEPTH));
    check("bp_s_ready_low", 64'(ifc.s_ready), 64'd0);
    check("bp_fifo_full", 64'(dut.fifo_count_q), 64'(RES_DEPTH));
    check("bp_err", 64'(ifc.err), 64'd0);
    ifc.m_ready = 1'b1;
    beat(bp[9], 50, acc);
    check("bp_resume", 64'(acc), 64'd1);
    drain(50);
    check("bp_s_ready_after", 64'(ifc.s_ready), 64'd1);
    ifc.m_ready = 1'b0;

    // ---- wrap-around with random sink readiness ----
    n_pop = 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 6 * RES_DEPTH; i++) begin
      beat(rnd_vec(), 100, acc);
      check("wrap_accept", 64'(acc), 64'd1);
    end
    drain(400);
    rand_rdy = 1'b0;
    ifc.m_ready = 1'b0;
    check("wrap_pops", 64'(n_pop), 64'(3 * RES_DEPTH));
    check("wrap_err", 64'(ifc.err), 64'd0);

    // ---- asynchronous reset mid-operation ----
    sb_on = 1'b0;
    send(rnd_vec());
    send(rnd_vec());
    send(rnd_vec());
    send(rnd_vec());
    send(rnd_vec());                // HOLD with two pairs in flight
    #3 rst = 1'b1;
    #1;
    check("arst_s_ready", 64'(ifc.s_ready), 64'd0);
    check("arst_add_in_valid", 64'(ifc.add_in_valid), 64'd0);
    check("arst_op1", 64'(ifc.add_op1), 64'd0);
    check("arst_op2", 64'(ifc.add_op2), 64'd0);
    check("arst_m_valid", 64'(ifc.m_valid), 64'd0);
    check("arst_inflight", 64'(dut.inflight_q), 64'd0);
    check("arst_err", 64'(ifc.err), 64'd0);
    #2 rst = 1'b0;
    have_b1 = 1'b0;
    q.delete();
    step();
    check("arst_s_ready_empty", 64'(ifc.s_ready), 64'd1);
    check("arst_err_before_late", 64'(ifc.err), 64'd0);
    step();
    check("arst_late_err", 64'(ifc.err), 64'd1);
    step();
    step();
    check("arst_err_sticky", 64'(ifc.err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
